multi_cycle_seq: RTL and testbench
==================================

// Module: multi_cycle_seq
// PURPOSE
//  Sequences multi-cycle instructions (e.g. PUSHA) flagged by the control unit's 5-bit multi field.
//  Expands one decoded instruction into multi+1 micro-ops and advances register index and address offset each cycle.
//  Holds PC/IR fetch via stall until the last micro-op.
//  Defers interrupts to instruction boundaries; sits between control decode and the PC/regfile/memory datapath.
// PARAMETERS
//  CNT_W     5   width of multi count and micro-op index
//  REG_W     5   register index width (32 registers)
//  OFF_W     8   address offset width
//  ADDR_STEP 4   byte offset added per micro-op
// PORTS
//  clk       in   1      system clock
//  reset     in   1      synchronous, active-high reset
//  start     in   1      decoded instruction valid this cycle
//  multi     in   CNT_W  extra micro-ops beyond the first (0 = single-cycle op)
//  base_reg  in   REG_W  first register of the sequence
//  irq       in   1      interrupt request (level)
//  busy      out  1      sequence in progress (state RUN)
//  stall     out  1      hold PC and IR this cycle
//  uvalid    out  1      micro-op valid; gates werf/mwr
//  ureg      out  REG_W  register index for current micro-op
//  uoff      out  OFF_W  address offset for current micro-op
//  done      out  1      last micro-op of instruction this cycle
//  irq_ok    out  1      irq may be taken this cycle (instruction boundary)
// BEHAVIOUR
//  Reset: clk edge with reset=1 -> state IDLE, idx=0, remaining=0; while reset=1 all outputs forced 0.
//  Priority: reset > irq > start, same as control decode.
//  State IDLE (irq_ok=1, busy=0):
//   - irq=1: uvalid=0, stall=0, done=0; start ignored; state stays IDLE.
//   - start=1, multi=0: uvalid=1, ureg=base_reg, uoff=0, done=1, stall=0; stay IDLE.
//   - start=1, multi>0: uvalid=1, ureg=base_reg, uoff=0, stall=1, done=0.
//     Latch base_reg; remaining<=multi; idx<=1; ->RUN.
//   - start=0: all outputs 0 except irq_ok.
//  State RUN (irq_ok=0, busy=1, uvalid=1):
//   - ureg = (base_latched + idx) mod 2^REG_W; R31 not skipped.
//   - uoff = idx*ADDR_STEP, truncated to OFF_W.
//   - idx == remaining: stall=0, done=1, ->IDLE; otherwise stall=1, idx<=idx+1.
//   - start, multi, base_reg, irq ignored; irq is held off, not lost (level input).
//  Latency: multi+1 cycles per instruction, one micro-op per cycle, no bubbles.
//   - start in the cycle after done begins a new sequence at once.
//  Reset mid-sequence: abort; no done pulse; partial micro-ops are not undone.
//  All outputs are combinational from state/idx/inputs; state, idx, remaining and base_latched are registered.
// STRUCTURE
//  - State encodings (IDLE=1'b0, RUN=1'b1) and MULTI_W go in risc_constants.vh next to op/alu codes.
//  - Single flat module; no sub-module is natural (one counter plus a 2-state FSM).
// TESTING
//  1. start, multi=0, base_reg=5 -> same cycle: uvalid=1, ureg=5, uoff=0, done=1, stall=0; busy stays 0.
//  2. start, multi=7, base_reg=0 -> 8 cycles: ureg 0..7, uoff 0,4,...,28.
//     stall=1 in cycles 0-6, 0 in cycle 7; done only in cycle 7.
//  3. start, multi=3, base_reg=30 -> ureg 30,31,0,1; uoff 0,4,8,12.
//  4. irq=1 at RUN cycle 2 of multi=7 -> irq_ok=0 until IDLE.
//     irq_ok=1 the cycle after done; irq+start together in IDLE -> uvalid=0, irq_ok=1.
//  5. reset=1 at micro-op 3 of multi=7 -> outputs 0 while asserted, IDLE after, no done.
//     Then start, multi=1, base_reg=4 -> ureg 4,5.
//  6. Back-to-back: multi=2 then start with multi=1 the cycle after done -> 5 contiguous uvalid cycles, done at cycles 2 and 4.

Source files
------------

// File: rtl/multi_cycle_seq_pkg.sv
// multi_cycle_seq_pkg: shared widths, step size and state encoding for the micro-op sequencer
package multi_cycle_seq_pkg;
    localparam int CNT_W     = 5;
    localparam int REG_W     = 5;
    localparam int OFF_W     = 8;
    localparam int ADDR_STEP = 4;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/multi_cycle_seq.sv
// multi_cycle_seq: expands one decoded instruction into multi+1 micro-ops, stalling fetch and deferring irq
module multi_cycle_seq
    import multi_cycle_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] multi,
    input  logic [REG_W-1:0] base_reg,
    input  logic             irq,
    output logic             busy,
    output logic             stall,
    output logic             uvalid,
    output logic [REG_W-1:0] ureg,
    output logic [OFF_W-1:0] uoff,
    output logic             done,
    output logic             irq_ok
);
    state_t           r_state;
    state_t           w_state_n;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_rem;
    logic [REG_W-1:0] r_base;
    logic             w_run;
    logic             w_go;
    logic             w_last;
    assign w_run  = r_state == RUN;
    assign w_go   = !reset && !w_run && !irq && start;
    assign w_last = w_run && r_idx == r_rem;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_rem   <= '0;
            r_base  <= '0;
        end else begin
            r_state <= w_state_n;
            if (w_go && multi != '0) begin
                r_base <= base_reg;
                r_rem  <= multi;
                r_idx  <= CNT_W'(1);
            end else if (w_run) begin
                r_idx <= w_last ? '0 : r_idx + CNT_W'(1);
            end
        end
    end
    always_comb begin
        w_state_n = r_state;
        if (w_go && multi != '0) w_state_n = RUN;
        else if (w_last) w_state_n = IDLE;
    end
    // Reset forces every output low; in IDLE an irq suppresses the start.
    always_comb begin
        busy   = !reset && w_run;
        irq_ok = !reset && !w_run;
        uvalid = !reset && (w_run || w_go);
        done   = !reset && (w_last || (w_go && multi == '0));
        stall  = !reset && ((w_run && !w_last) || (w_go && multi != '0));
        ureg   = reset ? '0 : w_run ? r_base + REG_W'(r_idx) : w_go ? base_reg : '0;
        uoff   = (!reset && w_run) ? OFF_W'(r_idx) * OFF_W'(ADDR_STEP) : '0;
    end
endmodule

// File: tb/tb_multi_cycle_seq.sv
// tb_multi_cycle_seq: directed vectors for multi_cycle_seq with hand-computed expectations
module tb_multi_cycle_seq;
    logic       clk = 0;
    logic       reset, start, irq;
    logic [4:0] multi, base_reg;
    logic       busy, stall, uvalid, done, irq_ok;
    logic [4:0] ureg;
    logic [7:0] uoff;
    int n_chk = 0;
    int n_err = 0;

    multi_cycle_seq dut (
        .clk(clk), .reset(reset), .start(start), .multi(multi), .base_reg(base_reg),
        .irq(irq), .busy(busy), .stall(stall), .uvalid(uvalid), .ureg(ureg),
        .uoff(uoff), .done(done), .irq_ok(irq_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic outs(input string t, input int uv, input int rg, input int of,
                        input int dn, input int st, input int bz, input int ok);
        chk({t, ".uvalid"}, 32'(uvalid), uv);
        chk({t, ".ureg"},   32'(ureg),   rg);
        chk({t, ".uoff"},   32'(uoff),   of);
        chk({t, ".done"},   32'(done),   dn);
        chk({t, ".stall"},  32'(stall),  st);
        chk({t, ".busy"},   32'(busy),   bz);
        chk({t, ".irq_ok"}, 32'(irq_ok), ok);
    endtask

    // One instruction of m+1 micro-ops; later cycles drive junk that must be ignored.
    task automatic run_seq(input string nm, input int m, input int b, input int irq_at, input int rst_at);
        for (int k = 0; k <= m; k++) begin
            @(negedge clk);
            reset    = (k == rst_at);
            irq      = (irq_at >= 0 && k >= irq_at);
            start    = 1;
            multi    = (k == 0) ? 5'(m) : 5'd31;
            base_reg = (k == 0) ? 5'(b) : 5'd17;
            #1;
            if (k == rst_at) begin
                outs($sformatf("%s_rst[%0d]", nm, k), 0, 0, 0, 0, 0, 0, 0);
                return;
            end
            outs($sformatf("%s[%0d]", nm, k), 1, (b + k) % 32, (4 * k) % 256,
                 int'(k == m), int'(k != m), int'(k != 0), int'(k == 0));
        end
    endtask

    task automatic idle(input string t, input logic i);
        @(negedge clk);
        reset = 0;
        start = 0;
        irq   = i;
        #1;
        outs(t, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        reset = 1; start = 1; multi = 5'd7; base_reg = 5'd5; irq = 0;
        @(negedge clk); #1;
        outs("reset", 0, 0, 0, 0, 0, 0, 0);
        run_seq("t1", 0, 5, -1, -1);
        idle("t1_idle", 0);
        run_seq("t2", 7, 0, -1, -1);
        idle("t2_idle", 0);
        run_seq("t3", 3, 30, -1, -1);
        idle("t3_idle", 0);
        run_seq("t4", 7, 0, 2, -1);
        @(negedge clk);
        irq = 1; start = 1; multi = 5'd0; base_reg = 5'd5;
        #1;
        outs("t4_irq_start", 0, 0, 0, 0, 0, 0, 1);
        idle("t4_hold", 1);
        idle("t4_clear", 0);
        run_seq("t5", 7, 0, -1, 3);
        @(negedge clk);
        reset = 1; start = 1; multi = 5'd2;
        #1;
        outs("t5_rst_hold", 0, 0, 0, 0, 0, 0, 0);
        idle("t5_post", 0);
        run_seq("t5b", 1, 4, -1, -1);
        run_seq("t6a", 2, 10, -1, -1);
        run_seq("t6b", 1, 20, -1, -1);
        idle("t6_idle", 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
